exec_timer_ctrl: RTL and testbench



---
 rtl/exec_timer_ctrl_pkg.sv | 27 ++
 rtl/exec_timer_ctrl_if.sv | 13 +
 rtl/exec_timer_ctrl_glitch_window_gen.sv | 58 +++++
 rtl/exec_timer_ctrl.sv | 114 +++++++++++
 tb/tb_exec_timer_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exec_timer_ctrl_pkg.sv
// Shared command codes, config register map and FSM encoding for the execution timer.
// Constants only: no logic, no latency, no flow control.
package exec_timer_ctrl_pkg;

   localparam logic [7:0] CMD_READ         = 8'h00;
   localparam logic [7:0] CMD_WRITE        = 8'h01;
   localparam logic [7:0] CMD_CONFIG_READ  = 8'h02;
   localparam logic [7:0] CMD_CONFIG_WRITE = 8'h03;

   localparam logic [15:0] ADDR_OFS_LO = 16'h0001;
   localparam logic [15:0] ADDR_OFS_HI = 16'h0002;
   localparam logic [15:0] ADDR_WIDTH  = 16'h0003;
   localparam logic [15:0] ADDR_CTRL   = 16'h0004;
   localparam logic [15:0] ADDR_CNT0   = 16'h0005;
   localparam logic [15:0] ADDR_CNT1   = 16'h0006;

   localparam int CTRL_ARM_BIT   = 0;
   localparam int CTRL_ABORT_BIT = 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RUN   = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/exec_timer_ctrl_if.sv
// Host config bus: fire-and-forget writes, accepted on the cycle they are presented.
// No backpressure; the slave samples every qualified cycle.
interface exec_timer_ctrl_if;

   logic        config_enable;
   logic [7:0]  cmd;
   logic [15:0] addr;
   logic [15:0] data_write;

   modport master (output config_enable, output cmd, output addr, output data_write);
   modport slave  (input  config_enable, input  cmd, input  addr, input  data_write);

endinterface

// File: rtl/exec_timer_ctrl_glitch_window_gen.sv
// One-shot glitch window: fires once per run when count hits offset, holds glitch_en for width cycles.
// glitch_en is registered (1 cycle after the compare); no backpressure, killed the edge after run/busy drop.
module exec_timer_ctrl_glitch_window_gen #(
   parameter int CNT_W = 32,
   parameter int WID_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             new_run,
   input  logic             run,
   input  logic             busy,
   input  logic             kill,
   input  logic [CNT_W-1:0] count,
   input  logic [CNT_W-1:0] offset,
   input  logic [WID_W-1:0] width,
   output logic             glitch_en
);

   logic             en_q;
   logic             fired_q;
   logic [WID_W-1:0] remain_q;
   logic             active;
   logic             hit;

   assign active    = run && busy && !kill;
   assign hit       = active && !fired_q && (width != '0) && (count == offset);
   assign glitch_en = en_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         en_q     <= 1'b0;
         fired_q  <= 1'b0;
         remain_q <= '0;
      end else begin
         if (new_run) begin
            fired_q <= 1'b0;
         end else if (hit) begin
            fired_q <= 1'b1;
         end

         // remain_q counts the cycles still owed after the current one
         if (!active) begin
            en_q     <= 1'b0;
            remain_q <= '0;
         end else if (hit) begin
            en_q     <= 1'b1;
            remain_q <= width - WID_W'(1);
         end else if (en_q) begin
            if (remain_q == '0) begin
               en_q <= 1'b0;
            end else begin
               remain_q <= remain_q - WID_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/exec_timer_ctrl.sv
// Arms on a host CTRL write, times the crypto busy window in clk cycles and schedules one glitch window.
// Config writes take effect on the next edge; all outputs are registered; no backpressure on any input.
module exec_timer_ctrl
   import exec_timer_ctrl_pkg::*;
#(
   parameter int CNT_W = 32,
   parameter int WID_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   exec_timer_ctrl_if.slave    cfg,
   input  logic                crypto_start,
   input  logic                crypto_busy,
   output logic [CNT_W-1:0]    exec_time_cnt,
   output logic                glitch_en,
   output logic                armed,
   output logic                done
);

   state_t           state_q;
   state_t           state_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] offset_q;
   logic [WID_W-1:0] width_q;
   logic             armed_q;
   logic             done_q;

   logic             cfg_wr;
   logic             ctrl_wr;
   logic             abort_req;
   logic             arm_req;
   logic             arm_ok;
   logic             in_run;

   assign cfg_wr    = cfg.config_enable && (cfg.cmd == CMD_CONFIG_WRITE);
   assign ctrl_wr   = cfg_wr && (cfg.addr == ADDR_CTRL);
   assign abort_req = ctrl_wr && cfg.data_write[CTRL_ABORT_BIT];
   assign arm_req   = ctrl_wr && cfg.data_write[CTRL_ARM_BIT] && !abort_req;
   // Re-arming while already ARMED is harmless and also swallows a coincident start
   assign arm_ok    = arm_req && (state_q != ST_RUN);
   assign in_run    = (state_q == ST_RUN);

   always_comb begin
      state_d = state_q;
      if (abort_req) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: if (arm_ok) state_d = ST_ARMED;
            ST_ARMED:         if (!arm_ok && crypto_start) state_d = ST_RUN;
            ST_RUN:           if (!crypto_busy) state_d = ST_DONE;
            default:          state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         armed_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         armed_q <= (state_d == ST_ARMED);
         done_q  <= (state_d == ST_DONE);
      end
   end

   // Counter saturates at all-ones; an abort freezes it for post-mortem readout
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (arm_ok) begin
         cnt_q <= '0;
      end else if (in_run && crypto_busy && !abort_req && !(&cnt_q)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         offset_q <= '0;
         width_q  <= '0;
      end else if (cfg_wr && !in_run) begin
         case (cfg.addr)
            ADDR_OFS_LO: offset_q[15:0]  <= cfg.data_write;
            ADDR_OFS_HI: offset_q[31:16] <= cfg.data_write;
            ADDR_WIDTH:  width_q         <= cfg.data_write[WID_W-1:0];
            default:     ;
         endcase
      end
   end

   exec_timer_ctrl_glitch_window_gen #(
      .CNT_W (CNT_W),
      .WID_W (WID_W)
   ) u_glitch (
      .clk       (clk),
      .rst       (rst),
      .new_run   (arm_ok),
      .run       (in_run),
      .busy      (crypto_busy),
      .kill      (abort_req),
      .count     (cnt_q),
      .offset    (offset_q),
      .width     (width_q),
      .glitch_en (glitch_en)
   );

   assign exec_time_cnt = cnt_q;
   assign armed         = armed_q;
   assign done          = done_q;

endmodule

// File: tb/tb_exec_timer_ctrl.sv
// Self-checking bench for exec_timer_ctrl: scenario tasks against a window-arithmetic reference model.
module tb_exec_timer_ctrl;
   import exec_timer_ctrl_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        crypto_start;
   logic        crypto_busy;
   logic [31:0] exec_time_cnt;
   logic        glitch_en;
   logic        armed;
   logic        done;

   int          n_checks = 0;
   int          n_fail   = 0;

   longint      m_ofs    = 0;
   longint      m_wid    = 0;
   bit          m_in_run = 1'b0;

   exec_timer_ctrl_if cfg();

   exec_timer_ctrl #(.CNT_W(32), .WID_W(16)) dut (
      .clk           (clk),
      .rst           (rst),
      .cfg           (cfg),
      .crypto_start  (crypto_start),
      .crypto_busy   (crypto_busy),
      .exec_time_cnt (exec_time_cnt),
      .glitch_en     (glitch_en),
      .armed         (armed),
      .done          (done)
   );

   always #5 clk = ~clk;

   // Glitch is high in RUN cycle k (counter value k) for k in (o, o+w], clipped to the n busy cycles plus the exit cycle
   function automatic bit exp_glitch(longint k, longint n, longint o, longint w);
      return (w != 0) && (o < n) && (k > o) && (k <= o + w) && (k <= n);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_cmd(input logic [7:0] c, input logic [15:0] a, input logic [15:0] d);
      cfg.config_enable = 1'b1;
      cfg.cmd           = c;
      cfg.addr          = a;
      cfg.data_write    = d;
      if (c == CMD_CONFIG_WRITE && !m_in_run) begin
         if (a == ADDR_OFS_LO) m_ofs[15:0]  = d;
         if (a == ADDR_OFS_HI) m_ofs[31:16] = d;
         if (a == ADDR_WIDTH)  m_wid        = longint'(d);
      end
      tick();
      cfg.config_enable = 1'b0;
      cfg.cmd           = 8'h00;
      cfg.addr          = 16'h0000;
      cfg.data_write    = 16'h0000;
   endtask

   task automatic do_run(input string name, input int n, input int inj_k,
                         input logic [15:0] inj_addr, input logic [15:0] inj_data);
      longint o;
      longint w;
      int     highs;
      int     exp_highs;
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_CTRL, 16'h0001);
      n_checks++;
      if (armed !== 1'b1) begin n_fail++; $display("FAIL %s armed: got %b want 1", name, armed); end
      o = m_ofs;
      w = m_wid;
      crypto_start = 1'b1;
      crypto_busy  = 1'b1;
      tick();
      crypto_start = 1'b0;
      m_in_run     = 1'b1;
      highs        = 0;
      exp_highs    = 0;
      for (int k = 0; k <= n; k++) begin
         if (k == n) crypto_busy = 1'b0;
         n_checks++;
         if (exec_time_cnt !== 32'(k)) begin
            n_fail++; $display("FAIL %s cnt k=%0d: got %0d want %0d", name, k, exec_time_cnt, k);
         end
         n_checks++;
         if (glitch_en !== exp_glitch(k, n, o, w)) begin
            n_fail++; $display("FAIL %s glitch k=%0d: got %b want %b", name, k, glitch_en, exp_glitch(k, n, o, w));
         end
         if (glitch_en === 1'b1) highs++;
         if (exp_glitch(k, n, o, w)) exp_highs++;
         if (k == inj_k) cfg_cmd(CMD_CONFIG_WRITE, inj_addr, inj_data);
         else tick();
      end
      m_in_run = 1'b0;
      n_checks++;
      if (done !== 1'b1 || armed !== 1'b0) begin
         n_fail++; $display("FAIL %s done/armed: got %b/%b want 1/0", name, done, armed);
      end
      n_checks++;
      if (exec_time_cnt !== 32'(n)) begin
         n_fail++; $display("FAIL %s final cnt: got %0d want %0d", name, exec_time_cnt, n);
      end
      n_checks++;
      if (glitch_en !== 1'b0) begin n_fail++; $display("FAIL %s glitch after done: got %b want 0", name, glitch_en); end
      n_checks++;
      if (highs != exp_highs) begin
         n_fail++; $display("FAIL %s glitch cycles: got %0d want %0d", name, highs, exp_highs);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst   = 1'b0;
      m_ofs = 0;
      m_wid = 0;
      n_checks++;
      if ({exec_time_cnt, glitch_en, armed, done} !== 35'd0) begin
         n_fail++; $display("FAIL reset outputs: got cnt=%0h g=%b a=%b d=%b want all 0", exec_time_cnt, glitch_en, armed, done);
      end
      crypto_start = 1'b1;
      crypto_busy  = 1'b1;
      tick();
      crypto_start = 1'b0;
      tick();
      crypto_busy = 1'b0;
      n_checks++;
      if (armed !== 1'b0 || exec_time_cnt !== 32'd0) begin
         n_fail++; $display("FAIL idle start ignored: got armed=%b cnt=%0d want 0/0", armed, exec_time_cnt);
      end
   endtask

   task automatic test_run_timing();
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_WIDTH, 16'd0);
      do_run("run_timing", 100, -1, 16'h0, 16'h0);
   endtask

   task automatic test_glitch_window();
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_OFS_LO, 16'd20);
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_OFS_HI, 16'd0);
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_WIDTH, 16'd3);
      do_run("glitch_window", 50, -1, 16'h0, 16'h0);
   endtask

   task automatic test_truncation();
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_OFS_LO, 16'd48);
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_WIDTH, 16'd10);
      do_run("truncation", 50, -1, 16'h0, 16'h0);
   endtask

   task automatic test_blocked_writes();
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_OFS_LO, 16'd5);
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_WIDTH, 16'd2);
      do_run("blocked_ofs", 20, 2, ADDR_OFS_LO, 16'd40);
      do_run("blocked_wid", 20, 3, ADDR_WIDTH, 16'd7);
      do_run("blocked_after", 20, -1, 16'h0, 16'h0);
   endtask

   task automatic test_arm_start_same_cycle();
      crypto_start = 1'b1;
      crypto_busy  = 1'b1;
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_CTRL, 16'h0001);
      crypto_start = 1'b0;
      tick();
      n_checks++;
      if (armed !== 1'b1 || done !== 1'b0 || exec_time_cnt !== 32'd0) begin
         n_fail++; $display("FAIL arm_start_same: got armed=%b done=%b cnt=%0d want 1/0/0", armed, done, exec_time_cnt);
      end
      crypto_busy = 1'b0;
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_CTRL, 16'h0002);
      n_checks++;
      if (armed !== 1'b0) begin n_fail++; $display("FAIL abort_from_armed: got armed=%b want 0", armed); end
   endtask

   task automatic test_abort();
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_OFS_LO, 16'd25);
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_WIDTH, 16'd20);
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_CTRL, 16'h0001);
      crypto_start = 1'b1;
      crypto_busy  = 1'b1;
      tick();
      crypto_start = 1'b0;
      m_in_run     = 1'b1;
      for (int k = 0; k <= 30; k++) begin
         n_checks++;
         if (glitch_en !== exp_glitch(k, 1000, 25, 20)) begin
            n_fail++; $display("FAIL abort glitch k=%0d: got %b want %b", k, glitch_en, exp_glitch(k, 1000, 25, 20));
         end
         if (k < 30) tick();
      end
      n_checks++;
      if (exec_time_cnt !== 32'd30) begin n_fail++; $display("FAIL abort pre cnt: got %0d want 30", exec_time_cnt); end
      // ABORT and ARM together: abort must win
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_CTRL, 16'h0003);
      m_in_run = 1'b0;
      n_checks++;
      if (armed !== 1'b0 || done !== 1'b0 || glitch_en !== 1'b0 || exec_time_cnt !== 32'd30) begin
         n_fail++; $display("FAIL abort state: got a=%b d=%b g=%b cnt=%0d want 0/0/0/30", armed, done, glitch_en, exec_time_cnt);
      end
      crypto_start = 1'b1;
      tick();
      crypto_start = 1'b0;
      tick();
      tick();
      n_checks++;
      if (armed !== 1'b0 || glitch_en !== 1'b0 || exec_time_cnt !== 32'd30) begin
         n_fail++; $display("FAIL abort start ignored: got a=%b g=%b cnt=%0d want 0/0/30", armed, glitch_en, exec_time_cnt);
      end
      crypto_busy = 1'b0;
   endtask

   task automatic test_saturation();
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_WIDTH, 16'd0);
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_CTRL, 16'h0001);
      crypto_start = 1'b1;
      crypto_busy  = 1'b1;
      tick();
      crypto_start = 1'b0;
      force dut.cnt_q = 32'hFFFF_FFFE;
      tick();
      release dut.cnt_q;
      for (int i = 0; i < 5; i++) tick();
      n_checks++;
      if (exec_time_cnt !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL saturation: got %0h want ffffffff", exec_time_cnt);
      end
      crypto_busy = 1'b0;
      tick();
      n_checks++;
      if (done !== 1'b1 || exec_time_cnt !== 32'hFFFF_FFFF || glitch_en !== 1'b0) begin
         n_fail++; $display("FAIL saturation done: got d=%b cnt=%0h g=%b want 1/ffffffff/0", done, exec_time_cnt, glitch_en);
      end
   endtask

   task automatic test_reset_midrun();
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_OFS_LO, 16'd3);
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_WIDTH, 16'd30);
      cfg_cmd(CMD_CONFIG_WRITE, ADDR_CTRL, 16'h0001);
      crypto_start = 1'b1;
      crypto_busy  = 1'b1;
      tick();
      crypto_start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      n_checks++;
      if (glitch_en !== 1'b1) begin n_fail++; $display("FAIL reset_midrun pre glitch: got %b want 1", glitch_en); end
      rst = 1'b1;
      tick();
      rst   = 1'b0;
      m_ofs = 0;
      m_wid = 0;
      n_checks++;
      if ({exec_time_cnt, glitch_en, armed, done} !== 35'd0) begin
         n_fail++; $display("FAIL reset_midrun outputs: got cnt=%0h g=%b a=%b d=%b want all 0", exec_time_cnt, glitch_en, armed, done);
      end
      for (int i = 0; i < 20; i++) begin
         tick();
         n_checks++;
         if (glitch_en !== 1'b0 || exec_time_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_midrun after i=%0d: got g=%b cnt=%0d want 0/0", i, glitch_en, exec_time_cnt);
         end
      end
      crypto_busy = 1'b0;
      tick();
      do_run("post_reset_cfg", 10, -1, 16'h0, 16'h0);
   endtask

   task automatic test_random();
      logic [15:0] o_lo;
      logic [15:0] o_hi;
      logic [15:0] w;
      logic [7:0]  bad_cmd;
      int          n;
      for (int it = 0; it < 10; it++) begin
         o_lo    = 16'($urandom_range(0, 40));
         o_hi    = ($urandom_range(0, 3) == 0) ? 16'd1 : 16'd0;
         w       = 16'($urandom_range(0, 8));
         n       = int'($urandom_range(1, 45));
         bad_cmd = 8'($urandom_range(0, 2));
         cfg_cmd(CMD_CONFIG_WRITE, ADDR_OFS_LO, o_lo);
         cfg_cmd(CMD_CONFIG_WRITE, ADDR_OFS_HI, o_hi);
         cfg_cmd(CMD_CONFIG_WRITE, ADDR_WIDTH, w);
         cfg_cmd(bad_cmd, ADDR_OFS_LO, 16'($urandom));
         cfg_cmd(CMD_CONFIG_WRITE, ADDR_CNT0, 16'($urandom));
         do_run($sformatf("random%0d", it), n, -1, 16'h0, 16'h0);
      end
   endtask

   initial begin
      rst               = 1'b1;
      crypto_start      = 1'b0;
      crypto_busy       = 1'b0;
      cfg.config_enable = 1'b0;
      cfg.cmd           = 8'h00;
      cfg.addr          = 16'h0000;
      cfg.data_write    = 16'h0000;
      test_reset();
      test_run_timing();
      test_glitch_window();
      test_truncation();
      test_blocked_writes();
      test_arm_start_same_cycle();
      test_abort();
      test_saturation();
      test_reset_midrun();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
